// File: rtl/sni_match_scheduler.sv
// Sequences one SNI string at a time through a 2-bytes-per-cycle pattern matcher:
// clear, pack/feed, drain, report. Optional early exit on hit: define SNI_EARLY_EXIT_EN.
module sni_match_scheduler #(
  parameter int unsigned CLR_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_sni_byte,
  input  logic        i_sni_valid,
  input  logic        i_sni_last,
  output logic        o_sni_ready,
  output logic        o_match_rst,
  output logic        o_match_data_valid,
  output logic [15:0] o_match_data,
  input  logic        i_match_hit,
  output logic        o_result_valid,
  output logic        o_result_hit,
  output logic [15:0] o_result_len
);

  localparam int unsigned CNT_MAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, REPORT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;   // 1 = high byte of the current word is held
  logic [7:0]       held_q, held_d;
  logic [15:0]      len_q, len_d;
  logic             hit_q, hit_d;
  logic             sample_q, sample_d; // hit window open (first word already seen)

  logic             ready_d, mrst_d, dv_d, rv_d, rhit_d;
  logic [15:0]      data_d, rlen_d;
  logic             accept, stop_feed;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    held_d    = held_q;
    len_d     = len_q;
    hit_d     = hit_q;
    sample_d  = sample_q;
    dv_d      = 1'b0;
    data_d    = o_match_data;
    rv_d      = 1'b0;
    rhit_d    = o_result_hit;
    rlen_d    = o_result_len;
    stop_feed = 1'b0;

    accept = (state_q == FEED) && i_sni_valid && o_sni_ready;

    if (sample_q && (state_q == FEED || state_q == DRAIN) && i_match_hit)
      hit_d = 1'b1;
    if (o_match_data_valid)
      sample_d = 1'b1;

`ifdef SNI_EARLY_EXIT_EN
    stop_feed = hit_d;
`else
    stop_feed = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (i_sni_valid) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == '0) state_d = FEED;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FEED: begin
        if (accept) begin
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          if (!stop_feed) begin
            if (phase_q) begin
              dv_d   = 1'b1;
              data_d = {held_q, i_sni_byte};
            end else if (i_sni_last) begin
              dv_d   = 1'b1;
              data_d = {i_sni_byte, PAD_BYTE};
            end else begin
              held_d = i_sni_byte;
            end
          end
          phase_d = ~phase_q;
          if (i_sni_last) begin
            phase_d = 1'b0;
            if (stop_feed) begin
              state_d = REPORT;
            end else begin
              state_d = DRAIN;
              cnt_d   = CNT_W'(DRAIN_CYCLES);
            end
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = REPORT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      REPORT: begin
        state_d = i_sni_valid ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Per-string state is wiped on every entry into CLEAR.
    if (state_d == CLEAR && state_q != CLEAR) begin
      cnt_d    = CNT_W'(CLR_CYCLES - 1);
      hit_d    = 1'b0;
      sample_d = 1'b0;
      len_d    = '0;
      phase_d  = 1'b0;
    end

    if (state_d == REPORT) begin
      rv_d   = 1'b1;
      rhit_d = hit_d;
      rlen_d = len_d;
    end

    ready_d = (state_d == FEED);
    mrst_d  = (state_d == CLEAR);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      phase_q            <= 1'b0;
      held_q             <= '0;
      len_q              <= '0;
      hit_q              <= 1'b0;
      sample_q           <= 1'b0;
      o_sni_ready        <= 1'b0;
      o_match_rst        <= 1'b1;
      o_match_data_valid <= 1'b0;
      o_match_data       <= '0;
      o_result_valid     <= 1'b0;
      o_result_hit       <= 1'b0;
      o_result_len       <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      phase_q            <= phase_d;
      held_q             <= held_d;
      len_q              <= len_d;
      hit_q              <= hit_d;
      sample_q           <= sample_d;
      o_sni_ready        <= ready_d;
      o_match_rst        <= mrst_d;
      o_match_data_valid <= dv_d;
      o_match_data       <= data_d;
      o_result_valid     <= rv_d;
      o_result_hit       <= rhit_d;
      o_result_len       <= rlen_d;
    end
  end

endmodule
